issue_scoreboard: RTL
=====================

# issue_scoreboard

In-order issue stage between the instruction decoder and the execute units of the out-of-order MIPS32 core. It accepts one decoded instruction per cycle over a valid/ready handshake and tracks pending register writes in a 32-entry busy scoreboard. It stalls on RAW and WAW hazards, serializes control-flow instructions (beq, j, jal, jr, syscall) until they resolve, and holds the issued instruction in a one-entry output register.

## Interface
Parameters:
- DATA_W, 64, width of the opaque instruction payload carried with each instruction (PC, op flags, immediates).

Ports. One clock; reset is asynchronous and active-high.
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  async active-high reset
- in_valid  in  1  decoded instruction present
- in_ready  out  1  stage accepts instruction this cycle (combinational)
- in_rs, in_rt  in  5 each  source register indices
- in_rs_valid, in_rt_valid  in  1 each  the source is actually read
- in_dst  in  5  destination register (rd, rt or 31 for jal, selected upstream)
- in_dst_valid  in  1  instruction writes in_dst
- in_serialize  in  1  control-flow or syscall instruction
- in_payload  in  DATA_W  opaque payload
- out_valid  out  1  issued instruction held in output register
- out_ready  in  1  execute accepts
- out_payload  out  DATA_W  payload of issued instruction
- wb_valid  in  1  writeback completes
- wb_reg  in  5  register written back
- resolve_valid  in  1  serialized instruction resolved (pulse)
- flush  in  1  discard output register and return to RUN
- busy_mask  out  32  scoreboard, bit i = write to reg i pending
- state  out  2  FSM state, RUN=0 DRAIN=1 WAIT=2

## Operation
- Effective busy: eff_busy = busy_mask & ~(wb_valid ? onehot(wb_reg) : 0). Same-cycle writeback clears hazards.
- Register 0 is never busy. A set or clear aimed at reg 0 is ignored, and sources or destination at reg 0 never hazard.
- hazard = (in_rs_valid & eff_busy[in_rs]) | (in_rt_valid & eff_busy[in_rt]) | (in_dst_valid & eff_busy[in_dst]).
- slot_free = !out_valid | out_ready.
- Non-serialized instruction: in_ready = (state==RUN) & slot_free & !hazard & !flush.
- Serialized instruction: in_ready = state∈{RUN,DRAIN} & slot_free & (eff_busy==0) & !flush.
- Accept (in_valid & in_ready):
  - the output register loads the payload and out_valid goes to 1;
  - if in_dst_valid and in_dst≠0, busy[in_dst] is set.
- Set and clear of the same register in one cycle: the set wins.
- The output register clears when out_valid & out_ready and there is no accept that cycle.
- FSM:
  - RUN -> DRAIN: in_valid & in_serialize & !in_ready & !flush.
  - RUN/DRAIN -> WAIT: serialized instruction accepted.
  - WAIT -> RUN: resolve_valid.
  - DRAIN stays DRAIN until accept or flush. While in DRAIN, non-serialized instructions are not accepted.
  - Any state -> RUN on flush. Flush and resolve_valid together give RUN.
- Flush:
  - clears out_valid;
  - does not clear busy bits, because in-flight writes still complete;
  - blocks acceptance that cycle.
- A wb_valid for a register that is not busy is a no-op.
- resolve_valid outside WAIT is ignored.

## Timing
- Reset values: out_valid=0, out_payload=0, busy_mask=0, state=RUN. in_ready=1 when in_valid, no serialize, out_ready don't-care.
- Issue latency is 1 cycle: accepted at edge N, out_valid=1 from cycle N+1.
- A dependent instruction is accepted in the same cycle that wb_valid clears its source.
- In the cycle after an accept, busy_mask reflects the new destination bit.
- Back-to-back independent instructions sustain 1 per cycle while out_ready=1.
- Reset asserted mid-operation clears all state immediately, without waiting for clk.

## Test plan
- Reset, then addu r3<-r1,r2 accepted with out_ready=1:
  - out_valid=1 the next cycle;
  - busy_mask=0x00000008;
  - wb_valid wb_reg=3 clears it to 0.
- RAW:
  - issue a write to r5, then a reader of r5: in_ready=0;
  - pulse wb_reg=5: the reader is accepted in that same cycle;
  - busy_mask returns to 0 after the reader's own destination handling.
- WAW and reg 0:
  - a write to r0 leaves busy_mask=0;
  - a second write to busy r7 stalls until wb_reg=7;
  - a simultaneous wb_reg=7 and accept of a new r7 writer leaves bit 7 set.
- Serialize:
  - with r4 busy, present beq (reads r4): state=DRAIN, in_ready=0;
  - wb_reg=4: beq accepted, state=WAIT;
  - the next addu stalls until resolve_valid, then state=RUN.
- jal:
  - jal (dst=31) issues from RUN with busy=0: busy_mask=0x80000000, state=WAIT.
- Backpressure and flush:
  - with out_ready=0, out_valid holds and out_payload is stable, and in_ready=0;
  - flush with r2 busy and state=WAIT: out_valid=0, state=RUN, busy_mask still 0x00000004.

Source files
------------

// File: rtl/issue_scoreboard.sv
// issue_scoreboard
//   In-order issue stage for the MIPS32 core. It accepts one decoded
//   instruction per cycle and tracks pending register writes in a 32-entry
//   busy scoreboard. It stalls on RAW/WAW hazards and serializes
//   control-flow instructions until they resolve. The issued instruction
//   is held in a one-entry output register.
// Ports:
//   clk, rst                 clock, async active-high reset
//   in_valid/in_ready        decoder handshake (in_ready combinational)
//   in_rs/in_rt (+_valid)    source registers actually read
//   in_dst/in_dst_valid      destination register write
//   in_serialize             control-flow / syscall instruction
//   in_payload               opaque instruction payload
//   out_valid/out_ready      execute handshake, out_payload issued payload
//   wb_valid/wb_reg          writeback completion, clears busy bit
//   resolve_valid            serialized instruction resolved (pulse)
//   flush                    drop output register, return to RUN
//   busy_mask                scoreboard, bit i = write to reg i pending
//   state                    FSM state RUN=0 DRAIN=1 WAIT=2
module issue_scoreboard #(
  parameter int DATA_W = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [4:0]        in_rs,
  input  logic [4:0]        in_rt,
  input  logic              in_rs_valid,
  input  logic              in_rt_valid,
  input  logic [4:0]        in_dst,
  input  logic              in_dst_valid,
  input  logic              in_serialize,
  input  logic [DATA_W-1:0] in_payload,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_payload,
  input  logic              wb_valid,
  input  logic [4:0]        wb_reg,
  input  logic              resolve_valid,
  input  logic              flush,
  output logic [31:0]       busy_mask,
  output logic [1:0]        state
);

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    DRAIN = 2'd1,
    WAIT  = 2'd2
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [31:0]         r_busy;
  logic                r_out_valid;
  logic [DATA_W-1:0]   r_out_payload;

  logic [31:0]         w_wb_clr;
  logic [31:0]         w_eff_busy;
  logic [31:0]         w_set;
  logic                w_hazard;
  logic                w_slot_free;
  logic                w_accept;

  // A same-cycle writeback already counts as complete for hazard purposes.
  assign w_wb_clr    = wb_valid ? (32'd1 << wb_reg) : 32'd0;
  assign w_eff_busy  = r_busy & ~w_wb_clr;
  assign w_hazard    = (in_rs_valid  & w_eff_busy[in_rs]) |
                       (in_rt_valid  & w_eff_busy[in_rt]) |
                       (in_dst_valid & w_eff_busy[in_dst]);
  assign w_slot_free = ~r_out_valid | out_ready;

  // Serialized instructions wait for the whole scoreboard to drain, so any
  // outstanding write (not just their own operands) holds them off.
  always_comb begin
    in_ready = 1'b0;
    if (in_serialize)
      in_ready = ((r_state == RUN) | (r_state == DRAIN)) & w_slot_free &
                 (w_eff_busy == 32'd0) & ~flush;
    else
      in_ready = (r_state == RUN) & w_slot_free & ~w_hazard & ~flush;
  end

  assign w_accept = in_valid & in_ready;
  assign w_set    = (w_accept & in_dst_valid) ? (32'd1 << in_dst) : 32'd0;

  // Scoreboard: clear then set so a new writer of the retiring register wins;
  // bit 0 is forced low since r0 is hardwired zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      r_busy <= 32'd0;
    else
      r_busy <= ((r_busy & ~w_wb_clr) | w_set) & 32'hFFFF_FFFE;
  end

  // Output register: flush wins, then a new issue, then drain to execute.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_out_valid   <= 1'b0;
      r_out_payload <= '0;
    end else if (flush) begin
      r_out_valid   <= 1'b0;
    end else if (w_accept) begin
      r_out_valid   <= 1'b1;
      r_out_payload <= in_payload;
    end else if (r_out_valid & out_ready) begin
      r_out_valid   <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      r_state <= RUN;
    else
      r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      RUN: begin
        if (w_accept & in_serialize)
          w_state_nxt = WAIT;
        else if (in_valid & in_serialize & ~in_ready)
          w_state_nxt = DRAIN;
      end
      DRAIN: begin
        if (w_accept)
          w_state_nxt = WAIT;
      end
      WAIT: begin
        if (resolve_valid)
          w_state_nxt = RUN;
      end
      default: w_state_nxt = RUN;
    endcase
    if (flush)
      w_state_nxt = RUN;
  end

  assign out_valid   = r_out_valid;
  assign out_payload = r_out_payload;
  assign busy_mask   = r_busy;
  assign state       = r_state;

endmodule
